// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: registered immediate extension with a
// 2-entry output buffer and synchronous flush.
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic [1:0]       occupancy
);

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic [TAG_W-1:0] tag;
  } ent_t;

  localparam int PAD = OUT_W - IN_W;

  ent_t       buf_q [2];
  logic       head_q;
  logic       tail_q;
  logic [1:0] cnt_q;

  logic [OUT_W-1:0] sx;
  logic [OUT_W-1:0] ext;
  logic             push;
  logic             pop;

  assign in_ready  = (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign occupancy = cnt_q;
  assign out_data  = buf_q[head_q].data;
  assign out_tag   = buf_q[head_q].tag;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Decode the extension mode into the result word.
  always_comb begin
    sx  = {{PAD{in_imm[IN_W-1]}}, in_imm};
    ext = sx;
    unique case (1'b1)
      in_mode == 2'd0: ext = sx;
      in_mode == 2'd1: ext = {{PAD{1'b0}}, in_imm};
      in_mode == 2'd2: ext = {in_imm, {PAD{1'b0}}};
      in_mode == 2'd3: ext = {sx[OUT_W-3:0], 2'b00};
      default:         ext = sx;
    endcase
  end

  // FIFO state: pointers, count and entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q   <= 1'b0;
      tail_q   <= 1'b0;
      cnt_q    <= 2'd0;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
    end else if (flush) begin
      head_q <= 1'b0;
      tail_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      if (push) begin
        buf_q[tail_q] <= '{data: ext, tag: in_tag};
        tail_q        <= ~tail_q;
      end
      if (pop) head_q <= ~head_q;
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_imm = '0;
  logic [1:0]  in_mode = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
  logic [1:0]  occupancy;

  int pass = 0;
  int total = 0;

  imm_extend_pipe #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_imm(in_imm), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_ext(
    input logic [15:0] imm, input logic [1:0] mode);
    longint v;
    v = longint'(imm);
    if ((mode == 2'd0 || mode == 2'd3) && imm >= 16'h8000)
      v = v - 65536;
    if (mode == 2'd2) v = v * 65536;
    if (mode == 2'd3) v = v * 4;
    return v[31:0];
  endfunction

  task automatic drive(input logic v, input logic [15:0] imm,
                       input logic [1:0] mode, input logic [4:0] tag);
    in_valid = v;
    in_imm   = imm;
    in_mode  = mode;
    in_tag   = tag;
  endtask

  task automatic test_reset;
    @(negedge clk);
    total++;
    if ({out_valid, in_ready, occupancy, out_data, out_tag} !==
        {1'b0, 1'b1, 2'd0, 32'd0, 5'd0})
      $display("FAIL reset_state: got v=%b r=%b occ=%0d d=%h t=%h",
               out_valid, in_ready, occupancy, out_data, out_tag);
    else pass++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({out_valid, in_ready, occupancy, out_data, out_tag} !==
        {1'b0, 1'b1, 2'd0, 32'd0, 5'd0})
      $display("FAIL reset_hold: got v=%b r=%b occ=%0d d=%h t=%h",
               out_valid, in_ready, occupancy, out_data, out_tag);
    else pass++;
  endtask

  task automatic test_modes;
    logic [15:0] imms [6] = '{16'h0013, 16'h801B, 16'h801B,
                              16'h801B, 16'h801B, 16'h0013};
    logic [1:0]  mds  [6] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3};
    logic [31:0] exps [6] = '{32'h00000013, 32'hFFFF801B,
                              32'h0000801B, 32'h801B0000,
                              32'hFFFE006C, 32'h0000004C};
    mds[1] = 2'd0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, imms[i], mds[i], 5'(i + 1));
      @(negedge clk);
      drive(1'b0, '0, '0, '0);
      total++;
      if ({out_valid, occupancy, out_data, out_tag} !==
          {1'b1, 2'd1, exps[i], 5'(i + 1)})
        $display("FAIL mode_%0d: got v=%b occ=%0d d=%h t=%0d want d=%h",
                 i, out_valid, occupancy, out_data, out_tag, exps[i]);
      else pass++;
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0)
        $display("FAIL mode_drain_%0d: got v=%b want 0", i, out_valid);
      else pass++;
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] d1;
    out_ready = 1'b0;
    drive(1'b1, 16'hA5A5, 2'd0, 5'd1);
    @(negedge clk);
    d1 = ref_ext(16'hA5A5, 2'd0);
    total++;
    if ({in_ready, occupancy, out_tag} !== {1'b1, 2'd1, 5'd1})
      $display("FAIL bp_first: got r=%b occ=%0d t=%0d",
               in_ready, occupancy, out_tag);
    else pass++;
    drive(1'b1, 16'h1234, 2'd1, 5'd2);
    @(negedge clk);
    total++;
    if ({in_ready, occupancy, out_tag} !== {1'b0, 2'd2, 5'd1})
      $display("FAIL bp_full: got r=%b occ=%0d t=%0d want r=0 occ=2 t=1",
               in_ready, occupancy, out_tag);
    else pass++;
    drive(1'b1, 16'h0F0F, 2'd2, 5'd3);
    @(negedge clk);
    total++;
    if ({in_ready, occupancy, out_tag, out_data} !==
        {1'b0, 2'd2, 5'd1, d1})
      $display("FAIL bp_hold: got r=%b occ=%0d t=%0d d=%h want d=%h",
               in_ready, occupancy, out_tag, out_data, d1);
    else pass++;
    out_ready = 1'b1;
    @(negedge clk);
    total++;
    if ({in_ready, occupancy, out_tag, out_data} !==
        {1'b1, 2'd1, 5'd2, 32'h00001234})
      $display("FAIL bp_pop1: got r=%b occ=%0d t=%0d d=%h",
               in_ready, occupancy, out_tag, out_data);
    else pass++;
    @(negedge clk);
    drive(1'b0, '0, '0, '0);
    total++;
    if ({occupancy, out_tag, out_data} !== {2'd1, 5'd3, 32'h0F0F0000})
      $display("FAIL bp_tag3: got occ=%0d t=%0d d=%h",
               occupancy, out_tag, out_data);
    else pass++;
    @(negedge clk);
  endtask

  task automatic test_streaming;
    logic [15:0] imm;
    logic [1:0]  md;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      imm = 16'($urandom);
      md  = 2'($urandom);
      drive(1'b1, imm, md, 5'(i + 8));
      @(negedge clk);
      total++;
      if ({out_valid, occupancy, out_tag, out_data} !==
          {1'b1, 2'd1, 5'(i + 8), ref_ext(imm, md)})
        $display("FAIL stream_%0d: got v=%b occ=%0d t=%0d d=%h want %h",
                 i, out_valid, occupancy, out_tag, out_data,
                 ref_ext(imm, md));
      else pass++;
    end
    drive(1'b0, '0, '0, '0);
    @(negedge clk);
  endtask

  task automatic test_push_pop;
    out_ready = 1'b0;
    drive(1'b1, 16'h7FFF, 2'd3, 5'd20);
    @(negedge clk);
    total++;
    if ({occupancy, out_tag, out_data} !== {2'd1, 5'd20, 32'h0001FFFC})
      $display("FAIL pp_older: got occ=%0d t=%0d d=%h",
               occupancy, out_tag, out_data);
    else pass++;
    out_ready = 1'b1;
    drive(1'b1, 16'h8000, 2'd0, 5'd21);
    @(negedge clk);
    drive(1'b0, '0, '0, '0);
    total++;
    if ({occupancy, out_tag, out_data} !== {2'd1, 5'd21, 32'hFFFF8000})
      $display("FAIL pp_newer: got occ=%0d t=%0d d=%h",
               occupancy, out_tag, out_data);
    else pass++;
    @(negedge clk);
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    drive(1'b1, 16'h1111, 2'd1, 5'd4);
    @(negedge clk);
    drive(1'b1, 16'h2222, 2'd1, 5'd5);
    @(negedge clk);
    drive(1'b1, 16'h3333, 2'd1, 5'd6);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    drive(1'b0, '0, '0, '0);
    total++;
    if ({out_valid, in_ready, occupancy} !== {1'b0, 1'b1, 2'd0})
      $display("FAIL flush_full: got v=%b r=%b occ=%0d",
               out_valid, in_ready, occupancy);
    else pass++;
    drive(1'b1, 16'h4444, 2'd1, 5'd7);
    @(negedge clk);
    drive(1'b1, 16'h5555, 2'd1, 5'd9);
    flush = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    drive(1'b0, '0, '0, '0);
    @(negedge clk);
    total++;
    if ({out_valid, in_ready, occupancy} !== {1'b0, 1'b1, 2'd0})
      $display("FAIL flush_drop: got v=%b r=%b occ=%0d",
               out_valid, in_ready, occupancy);
    else pass++;
  endtask

  task automatic test_async_reset;
    out_ready = 1'b0;
    drive(1'b1, 16'hBEEF, 2'd2, 5'd30);
    @(negedge clk);
    drive(1'b1, 16'hCAFE, 2'd0, 5'd31);
    @(negedge clk);
    drive(1'b0, '0, '0, '0);
    total++;
    if ({occupancy, out_data} !== {2'd2, 32'hBEEF0000})
      $display("FAIL ar_pre: got occ=%0d d=%h", occupancy, out_data);
    else pass++;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, in_ready, occupancy, out_data, out_tag} !==
        {1'b0, 1'b1, 2'd0, 32'd0, 5'd0})
      $display("FAIL async_reset: got v=%b r=%b occ=%0d d=%h t=%h",
               out_valid, in_ready, occupancy, out_data, out_tag);
    else pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random;
    logic [36:0] q [$];
    logic        pu, po, fl;
    logic [15:0] imm;
    logic [1:0]  md;
    logic [4:0]  tg;
    int          errs = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      total++;
      if (q.size() == 0) begin
        if ({out_valid, in_ready, occupancy} !== {1'b0, 1'b1, 2'd0}) begin
          errs++;
          $display("FAIL rand_empty c=%0d: got v=%b r=%b occ=%0d",
                   c, out_valid, in_ready, occupancy);
        end else pass++;
      end else begin
        if ({out_valid, in_ready, occupancy, out_data, out_tag} !==
            {1'b1, q.size() < 2, 2'(q.size()), q[0]}) begin
          errs++;
          $display("FAIL rand_head c=%0d: got v=%b r=%b occ=%0d d=%h t=%0d want %h",
                   c, out_valid, in_ready, occupancy, out_data, out_tag, q[0]);
        end else pass++;
      end
      if (errs > 5) break;
      imm = 16'($urandom);
      md  = 2'($urandom);
      tg  = 5'($urandom);
      drive(1'($urandom), imm, md, tg);
      out_ready = ($urandom_range(0, 2) != 0);
      fl = ($urandom_range(0, 19) == 0);
      flush = fl;
      pu = in_valid && q.size() < 2;
      po = out_ready && q.size() > 0;
      if (fl) q.delete();
      else begin
        if (po) void'(q.pop_front());
        if (pu) q.push_back({ref_ext(imm, md), tg});
      end
    end
    flush = 1'b0;
    drive(1'b0, '0, '0, '0);
  endtask

  initial begin
    test_reset();
    test_modes();
    test_backpressure();
    test_streaming();
    test_push_pop();
    test_flush();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Registered, parametrised immediate-extension unit for the datapath's decode stage. It accepts an IN_W-bit immediate plus a mode and tag over a valid/ready handshake, and produces the OUT_W-bit result one cycle later. Results pass through a 2-entry output buffer, so the execute stage can stall without losing data. Four extension modes are supported: sign, zero, upper-load and branch-offset (sign-extend then shift left by 2). A synchronous flush discards buffered results on a pipeline redirect.

## Interface
- IN_W, 16, immediate input width; must be at least 2
- OUT_W, 32, result width; must satisfy OUT_W >= IN_W + 2
- TAG_W, 5, width of the sideband tag (e.g. destination register) carried with each result
- clk  input  1  rising-edge clock for all state
- rst_n  input  1  asynchronous, active-low reset
- flush  input  1  synchronous; discards all buffered entries
- in_valid  input  1  immediate/mode/tag present
- in_ready  output  1  block can accept an input this cycle
- in_imm  input  IN_W  raw immediate
- in_mode  input  2  0 sign, 1 zero, 2 upper, 3 branch offset
- in_tag  input  TAG_W  sideband, passed through unchanged
- out_valid  output  1  out_data/out_tag hold a result
- out_ready  input  1  consumer accepts the result
- out_data  output  OUT_W  extended immediate
- out_tag  output  TAG_W  tag of the entry at the head of the buffer
- occupancy  output  2  number of buffered entries, 0..2

## Operation
- Extension is computed combinationally from in_imm/in_mode and written into the buffer on push. Arithmetic:
  - mode 0 (sign): replicate in_imm[IN_W-1] into bits OUT_W-1..IN_W.
  - mode 1 (zero): zero-fill bits OUT_W-1..IN_W.
  - mode 2 (upper): in_imm placed at bits OUT_W-1..OUT_W-IN_W; low bits zero.
  - mode 3 (branch): sign-extend to OUT_W, then shift left 2 with zero fill; no bits are lost, given OUT_W >= IN_W+2.
- Buffer: 2-entry FIFO (head/tail pointers, 1-bit each, plus count).
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
- in_ready = (occupancy != 2) and depends on registered state only. There is no combinational path from out_ready to in_ready.
- out_valid = (occupancy != 0). out_data/out_tag always reflect the head entry.
- Head entry stays stable while out_valid & ~out_ready.
- Push and pop in the same cycle: occupancy unchanged, and FIFO order is preserved.
- Push at occupancy 2 cannot occur, because in_ready is low.
- Pop at occupancy 0 cannot occur, because out_valid is low.
- flush: next edge sets occupancy to 0 and resets both pointers. A simultaneous push is dropped and a simultaneous pop has no further effect.
- Storage contents are not cleared by flush. out_data/out_tag are don't-care while out_valid is 0, except after reset.

## Timing
- Reset (rst_n low, asynchronous): occupancy=0, pointers=0, all storage=0, out_valid=0, in_ready=1, out_data=0, out_tag=0. These hold until the first push after rst_n deasserts.
- Reset asserted mid-operation: all buffered entries are lost immediately, without waiting for a clock edge.
- Latency: a push at edge N makes the result visible on out_data with out_valid=1 after edge N, i.e. in cycle N+1.
- Throughput: 1 result per cycle sustained while out_ready is held 1 (occupancy alternates 0→1 and stays at 1).
- With out_ready=0: two pushes fill the buffer, and in_ready drops in the cycle after the second push.
- When out_ready returns to 1, in_ready rises one cycle after the first pop.
- flush takes effect at the edge where it is sampled high. out_valid=0 and in_ready=1 in the following cycle.

## Test plan
- Reset then modes with IN_W=16, OUT_W=32, out_ready=1: in_imm 0x0013 mode 0 → 0x00000013; 0x801B mode 0 → 0xFFFF801B; 0x801B mode 1 → 0x0000801B; 0x801B mode 2 → 0x801B0000; 0x801B mode 3 → 0xFFFE006C; 0x0013 mode 3 → 0x0000004C. Each result appears exactly one cycle after its push.
- Back-pressure: out_ready=0, push tags 1, 2 and 3 on consecutive cycles → only 1 and 2 are accepted, in_ready=0, occupancy=2, head tag 1 held stable. Raise out_ready → results emerge in order 1 then 2, and tag 3 is accepted once in_ready returns to 1.
- Streaming: 8 back-to-back pushes with out_ready=1 → 8 results on consecutive cycles in order, occupancy never exceeds 1.
- Simultaneous push+pop at occupancy 1 → occupancy stays 1, and the popped result is the older entry.
- Flush: fill to 2, then assert flush together with in_valid → next cycle out_valid=0, occupancy=0, in_ready=1, and the pushed entry never appears.
- Asynchronous reset pulse mid-stream (between clock edges, occupancy=2) → out_valid=0, out_data=0 and in_ready=1 immediately, with no clock edge required.
